// File: rtl/instr_ctrl.sv
// -----------------------------------------------------------------------------
// instr_ctrl
//   Instruction register plus sequencing FSM for a small load/store-free CPU
//   datapath. An instruction word is captured while idle, decoded, and the
//   datapath is walked through read / execute / write-back steps with one
//   control strobe set per state.
//
// Ports
//   clk       in   1   rising-edge clock
//   reset     in   1   synchronous, active-high reset
//   in        in  16   instruction word
//   load      in   1   IR capture strobe (honoured only while waiting)
//   s         in   1   start strobe (honoured only while waiting)
//   w         out  1   high only while waiting
//   readnum   out  3   register file read index
//   writenum  out  3   register file write index
//   write     out  1   register file write enable
//   vsel      out  1   write-back source: 1 = datapath_in, 0 = C
//   loada/b/c out  1   A / B / C register load enables
//   loads     out  1   status register load enable
//   asel      out  1   A operand select: 1 = zero
//   bsel      out  1   B operand select: 0 = shifted B
//   ALUop     out  2   00 add, 01 sub, 10 and, 11 not-B
//   shift     out  2   shifter code
//   sximm8    out 16   sign-extended IR[7:0]
//
// Instruction fields
//   [15:13] opcode  [12:11] op  [10:8] Rn  [7:5] Rd  [4:3] sh  [2:0] Rm
//
// State table
//   state        | meaning
//   S_WAIT       | idle, IR may be loaded, waits for s
//   S_DECODE     | classify IR, no strobes
//   S_GET_A      | read Rn into A
//   S_GET_B      | read Rm into B
//   S_EXEC       | ALU/shift into C (status for CMP)
//   S_WRITE      | write C back to Rd
//   S_WRITE_IMM  | write sximm8 to Rn
// -----------------------------------------------------------------------------
module instr_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] in,
   input  logic        load,
   input  logic        s,
   output logic        w,
   output logic [2:0]  readnum,
   output logic [2:0]  writenum,
   output logic        write,
   output logic        vsel,
   output logic        loada,
   output logic        loadb,
   output logic        loadc,
   output logic        loads,
   output logic        asel,
   output logic        bsel,
   output logic [1:0]  ALUop,
   output logic [1:0]  shift,
   output logic [15:0] sximm8
);

   typedef enum logic [2:0] {
      S_WAIT      = 3'd0,
      S_DECODE    = 3'd1,
      S_GET_A     = 3'd2,
      S_GET_B     = 3'd3,
      S_EXEC      = 3'd4,
      S_WRITE     = 3'd5,
      S_WRITE_IMM = 3'd6
   } state_t;

   state_t      r_state;
   logic [15:0] r_ir;

   state_t      w_state_nxt;
   logic [15:0] w_ir_nxt;

   // classification of the current IR (used for DECODE / EXEC branching)
   logic        w_cur_mov_imm;
   logic        w_cur_mov_reg;
   logic        w_cur_mvn;
   logic        w_cur_alu;
   logic        w_cur_cmp;

   // classification of the IR that will be held next cycle (for outputs)
   logic [2:0]  w_nxt_opcode;
   logic [1:0]  w_nxt_op;
   logic        w_nxt_mov_reg;
   logic        w_nxt_mvn;
   logic        w_nxt_cmp;

   // next-cycle output values
   logic        w_w_nxt;
   logic [2:0]  w_readnum_nxt;
   logic [2:0]  w_writenum_nxt;
   logic        w_write_nxt;
   logic        w_vsel_nxt;
   logic        w_loada_nxt;
   logic        w_loadb_nxt;
   logic        w_loadc_nxt;
   logic        w_loads_nxt;
   logic        w_asel_nxt;
   logic        w_bsel_nxt;
   logic [1:0]  w_aluop_nxt;
   logic [1:0]  w_shift_nxt;

   assign w_cur_mov_imm = (r_ir[15:13] == 3'b110) && (r_ir[12:11] == 2'b10);
   assign w_cur_mov_reg = (r_ir[15:13] == 3'b110) && (r_ir[12:11] == 2'b00);
   assign w_cur_mvn     = (r_ir[15:13] == 3'b101) && (r_ir[12:11] == 2'b11);
   assign w_cur_alu     = (r_ir[15:13] == 3'b101) && (r_ir[12:11] != 2'b11);
   assign w_cur_cmp     = (r_ir[15:13] == 3'b101) && (r_ir[12:11] == 2'b01);

   // IR can only change while idle, so a load/start in the same WAIT cycle
   // hands the fresh word straight to DECODE.
   assign w_ir_nxt = ((r_state == S_WAIT) && load) ? in : r_ir;

   always_comb begin
      w_state_nxt = S_WAIT;
      unique case (r_state)
         S_WAIT:      w_state_nxt = s ? S_DECODE : S_WAIT;
         S_DECODE: begin
            if (w_cur_mov_imm)                   w_state_nxt = S_WRITE_IMM;
            else if (w_cur_mov_reg || w_cur_mvn) w_state_nxt = S_GET_B;
            else if (w_cur_alu)                  w_state_nxt = S_GET_A;
            else                                 w_state_nxt = S_WAIT;
         end
         S_GET_A:     w_state_nxt = S_GET_B;
         S_GET_B:     w_state_nxt = S_EXEC;
         S_EXEC:      w_state_nxt = w_cur_cmp ? S_WAIT : S_WRITE;
         S_WRITE:     w_state_nxt = S_WAIT;
         S_WRITE_IMM: w_state_nxt = S_WAIT;
         default:     w_state_nxt = S_WAIT;
      endcase
   end

   assign w_nxt_opcode  = w_ir_nxt[15:13];
   assign w_nxt_op      = w_ir_nxt[12:11];
   assign w_nxt_mov_reg = (w_nxt_opcode == 3'b110) && (w_nxt_op == 2'b00);
   assign w_nxt_mvn     = (w_nxt_opcode == 3'b101) && (w_nxt_op == 2'b11);
   assign w_nxt_cmp     = (w_nxt_opcode == 3'b101) && (w_nxt_op == 2'b01);

   // Outputs are decoded from the state/IR pair that will be registered, so
   // the output flops always agree with the state flops (pure Moore timing).
   always_comb begin
      w_w_nxt        = 1'b0;
      w_readnum_nxt  = 3'd0;
      w_writenum_nxt = 3'd0;
      w_write_nxt    = 1'b0;
      w_vsel_nxt     = 1'b0;
      w_loada_nxt    = 1'b0;
      w_loadb_nxt    = 1'b0;
      w_loadc_nxt    = 1'b0;
      w_loads_nxt    = 1'b0;
      w_asel_nxt     = 1'b0;
      w_bsel_nxt     = 1'b0;
      w_aluop_nxt    = 2'b00;
      w_shift_nxt    = 2'b00;
      unique case (w_state_nxt)
         S_WAIT:   w_w_nxt = 1'b1;
         S_DECODE: ;
         S_GET_A: begin
            w_readnum_nxt = w_ir_nxt[10:8];
            w_loada_nxt   = 1'b1;
         end
         S_GET_B: begin
            w_readnum_nxt = w_ir_nxt[2:0];
            w_loadb_nxt   = 1'b1;
         end
         S_EXEC: begin
            w_shift_nxt = w_ir_nxt[4:3];
            w_loadc_nxt = 1'b1;
            w_asel_nxt  = w_nxt_mov_reg || w_nxt_mvn;
            // MOV reg is 0 + shifted B, i.e. an add
            w_aluop_nxt = w_nxt_mov_reg ? 2'b00 : w_nxt_op;
            w_loads_nxt = w_nxt_cmp;
         end
         S_WRITE: begin
            w_writenum_nxt = w_ir_nxt[7:5];
            w_write_nxt    = 1'b1;
         end
         S_WRITE_IMM: begin
            w_writenum_nxt = w_ir_nxt[10:8];
            w_vsel_nxt     = 1'b1;
            w_write_nxt    = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_WAIT;
         r_ir     <= 16'h0000;
         w        <= 1'b1;
         readnum  <= 3'd0;
         writenum <= 3'd0;
         write    <= 1'b0;
         vsel     <= 1'b0;
         loada    <= 1'b0;
         loadb    <= 1'b0;
         loadc    <= 1'b0;
         loads    <= 1'b0;
         asel     <= 1'b0;
         bsel     <= 1'b0;
         ALUop    <= 2'b00;
         shift    <= 2'b00;
      end else begin
         r_state  <= w_state_nxt;
         r_ir     <= w_ir_nxt;
         w        <= w_w_nxt;
         readnum  <= w_readnum_nxt;
         writenum <= w_writenum_nxt;
         write    <= w_write_nxt;
         vsel     <= w_vsel_nxt;
         loada    <= w_loada_nxt;
         loadb    <= w_loadb_nxt;
         loadc    <= w_loadc_nxt;
         loads    <= w_loads_nxt;
         asel     <= w_asel_nxt;
         bsel     <= w_bsel_nxt;
         ALUop    <= w_aluop_nxt;
         shift    <= w_shift_nxt;
      end
   end

   assign sximm8 = {{8{r_ir[7]}}, r_ir[7:0]};

endmodule

// File: tb/tb_instr_ctrl.sv
module tb_instr_ctrl;

   logic        clk;
   logic        reset;
   logic [15:0] in;
   logic        load;
   logic        s;
   logic        w;
   logic [2:0]  readnum;
   logic [2:0]  writenum;
   logic        write;
   logic        vsel;
   logic        loada;
   logic        loadb;
   logic        loadc;
   logic        loads;
   logic        asel;
   logic        bsel;
   logic [1:0]  ALUop;
   logic [1:0]  shift;
   logic [15:0] sximm8;

   int n_assert = 0;
   int n_fail   = 0;

   instr_ctrl dut (
      .clk      (clk),
      .reset    (reset),
      .in       (in),
      .load     (load),
      .s        (s),
      .w        (w),
      .readnum  (readnum),
      .writenum (writenum),
      .write    (write),
      .vsel     (vsel),
      .loada    (loada),
      .loadb    (loadb),
      .loadc    (loadc),
      .loads    (loads),
      .asel     (asel),
      .bsel     (bsel),
      .ALUop    (ALUop),
      .shift    (shift),
      .sximm8   (sximm8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // strobes packed as {write, vsel, loada, loadb, loadc, loads, asel, bsel}
   task automatic chk_outs(input string tag, input logic exp_w, input logic [2:0] exp_rd,
                           input logic [2:0] exp_wr, input logic [7:0] exp_stb,
                           input logic [1:0] exp_alu, input logic [1:0] exp_sh);
      chk({tag, ".w"},        {15'd0, w},        {15'd0, exp_w});
      chk({tag, ".readnum"},  {13'd0, readnum},  {13'd0, exp_rd});
      chk({tag, ".writenum"}, {13'd0, writenum}, {13'd0, exp_wr});
      chk({tag, ".strobes"},
          {8'd0, write, vsel, loada, loadb, loadc, loads, asel, bsel}, {8'd0, exp_stb});
      chk({tag, ".ALUop"},    {14'd0, ALUop},    {14'd0, exp_alu});
      chk({tag, ".shift"},    {14'd0, shift},    {14'd0, exp_sh});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; in = 16'h0000; load = 1'b0; s = 1'b0;
      tick(); tick();
      chk_outs("rst", 1'b1, 3'd0, 3'd0, 8'h00, 2'b00, 2'b00);
      chk("rst.sximm8", sximm8, 16'h0000);

      // reset beats load and s
      in = 16'hD0FF; load = 1'b1; s = 1'b1;
      tick();
      chk_outs("rst_prio", 1'b1, 3'd0, 3'd0, 8'h00, 2'b00, 2'b00);
      chk("rst_prio.sximm8", sximm8, 16'h0000);
      reset = 1'b0; load = 1'b0; s = 1'b0;
      tick();
      chk("idle.w", {15'd0, w}, 16'h0001);

      // MOV R0,#7 ; load ignored outside WAIT
      in = 16'hD007; load = 1'b1; s = 1'b1;
      tick();
      chk_outs("movi.dec", 1'b0, 3'd0, 3'd0, 8'h00, 2'b00, 2'b00);
      chk("movi.dec.sximm8", sximm8, 16'h0007);
      in = 16'hFFFF; load = 1'b1; s = 1'b0;
      tick();
      chk_outs("movi.wimm", 1'b0, 3'd0, 3'd0, 8'hC0, 2'b00, 2'b00);
      chk("movi.wimm.sximm8", sximm8, 16'h0007);
      load = 1'b0;
      tick();
      chk_outs("movi.done", 1'b1, 3'd0, 3'd0, 8'h00, 2'b00, 2'b00);
      chk("movi.done.sximm8", sximm8, 16'h0007);

      // load without s stays in WAIT but updates IR
      in = 16'hD1FE; load = 1'b1;
      tick();
      chk("ld_only.w", {15'd0, w}, 16'h0001);
      chk("ld_only.sximm8", sximm8, 16'hFFFE);
      load = 1'b0; s = 1'b1;
      tick();
      chk("movn.dec.w", {15'd0, w}, 16'h0000);
      s = 1'b0;
      tick();
      chk_outs("movn.wimm", 1'b0, 3'd0, 3'd1, 8'hC0, 2'b00, 2'b00);
      chk("movn.sximm8", sximm8, 16'hFFFE);
      tick();
      chk("movn.done.w", {15'd0, w}, 16'h0001);

      // ADD R2,R1,R0,LSL#1
      in = 16'hA148; load = 1'b1; s = 1'b1;
      tick();
      chk_outs("add.dec", 1'b0, 3'd0, 3'd0, 8'h00, 2'b00, 2'b00);
      load = 1'b0; s = 1'b0;
      tick();
      chk_outs("add.geta", 1'b0, 3'd1, 3'd0, 8'h20, 2'b00, 2'b00);
      tick();
      chk_outs("add.getb", 1'b0, 3'd0, 3'd0, 8'h10, 2'b00, 2'b00);
      tick();
      chk_outs("add.exec", 1'b0, 3'd0, 3'd0, 8'h08, 2'b00, 2'b01);
      tick();
      chk_outs("add.write", 1'b0, 3'd0, 3'd2, 8'h80, 2'b00, 2'b00);
      tick();
      chk_outs("add.done", 1'b1, 3'd0, 3'd0, 8'h00, 2'b00, 2'b00);

      // CMP R0,R1 ; s held high mid-instruction is ignored
      in = 16'hA801; load = 1'b1; s = 1'b1;
      tick();
      chk("cmp.dec.w", {15'd0, w}, 16'h0000);
      load = 1'b0;
      tick();
      chk_outs("cmp.geta", 1'b0, 3'd0, 3'd0, 8'h20, 2'b00, 2'b00);
      tick();
      chk_outs("cmp.getb", 1'b0, 3'd1, 3'd0, 8'h10, 2'b00, 2'b00);
      s = 1'b0;
      tick();
      chk_outs("cmp.exec", 1'b0, 3'd0, 3'd0, 8'h0C, 2'b01, 2'b00);
      tick();
      chk_outs("cmp.done", 1'b1, 3'd0, 3'd0, 8'h00, 2'b00, 2'b00);

      // MVN R3,R5,LSR (sh=10)
      in = 16'hB875; load = 1'b1; s = 1'b1;
      tick();
      load = 1'b0; s = 1'b0;
      chk("mvn.dec.w", {15'd0, w}, 16'h0000);
      tick();
      chk_outs("mvn.getb", 1'b0, 3'd5, 3'd0, 8'h10, 2'b00, 2'b00);
      tick();
      chk_outs("mvn.exec", 1'b0, 3'd0, 3'd0, 8'h0A, 2'b11, 2'b10);
      tick();
      chk_outs("mvn.write", 1'b0, 3'd0, 3'd3, 8'h80, 2'b00, 2'b00);
      tick();
      chk("mvn.done.w", {15'd0, w}, 16'h0001);

      // MOV R4,R2,ASR (sh=11)
      in = 16'hC09A; load = 1'b1; s = 1'b1;
      tick();
      load = 1'b0; s = 1'b0;
      tick();
      chk_outs("movr.getb", 1'b0, 3'd2, 3'd0, 8'h10, 2'b00, 2'b00);
      tick();
      chk_outs("movr.exec", 1'b0, 3'd0, 3'd0, 8'h0A, 2'b00, 2'b11);
      tick();
      chk_outs("movr.write", 1'b0, 3'd0, 3'd4, 8'h80, 2'b00, 2'b00);
      tick();
      chk("movr.done.w", {15'd0, w}, 16'h0001);

      // undefined encoding: DECODE then straight back to WAIT
      in = 16'hE0AA; load = 1'b1; s = 1'b1;
      tick();
      load = 1'b0; s = 1'b0;
      chk_outs("undef.dec", 1'b0, 3'd0, 3'd0, 8'h00, 2'b00, 2'b00);
      tick();
      chk_outs("undef.done", 1'b1, 3'd0, 3'd0, 8'h00, 2'b00, 2'b00);
      chk("undef.sximm8", sximm8, 16'hFFAA);

      // reset during GET_B of an ADD
      in = 16'hA148; load = 1'b1; s = 1'b1;
      tick();
      load = 1'b0; s = 1'b0;
      tick();
      tick();
      chk_outs("midrst.getb", 1'b0, 3'd0, 3'd0, 8'h10, 2'b00, 2'b00);
      reset = 1'b1;
      tick();
      chk_outs("midrst.rst", 1'b1, 3'd0, 3'd0, 8'h00, 2'b00, 2'b00);
      chk("midrst.sximm8", sximm8, 16'h0000);
      reset = 1'b0;
      tick();
      chk_outs("midrst.after", 1'b1, 3'd0, 3'd0, 8'h00, 2'b00, 2'b00);
      in = 16'h0000; s = 1'b1;
      tick();
      s = 1'b0;
      chk_outs("zero.dec", 1'b0, 3'd0, 3'd0, 8'h00, 2'b00, 2'b00);
      tick();
      chk_outs("zero.done", 1'b1, 3'd0, 3'd0, 8'h00, 2'b00, 2'b00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
